// File: rtl/fft_frame_ctrl.sv
// Frame controller between an ADC sample stream and an FFT core: issues one config word per frame,
// then forces every frame to exactly 2^L beats. Define FFT_FRAME_CTRL_STATS_EN for saturating statistics.
module fft_frame_ctrl #(
    parameter int MAX_LOG2_LEN  = 13,
    parameter int CHANNELS      = 2,
    parameter int SAMPLE_W      = 32,
    parameter int CFG_W         = 16,
    parameter int SETTLE_CYCLES = 16
) (
    input  logic                         aclk,
    input  logic                         aresetn,
    input  logic                         start,
    input  logic [4:0]                   cfg_log2_len,
    input  logic                         cfg_fwd_inv,
    input  logic [CHANNELS*SAMPLE_W-1:0] s_axis_tdata,
    input  logic                         s_axis_tvalid,
    input  logic                         s_axis_tlast,
    output logic                         s_axis_tready,
    output logic [CFG_W-1:0]             m_cfg_tdata,
    output logic                         m_cfg_tvalid,
    input  logic                         m_cfg_tready,
    output logic [CHANNELS*SAMPLE_W-1:0] m_fft_tdata,
    output logic                         m_fft_tvalid,
    output logic                         m_fft_tlast,
    input  logic                         m_fft_tready,
    input  logic [CHANNELS*SAMPLE_W-1:0] s_res_tdata,
    input  logic                         s_res_tvalid,
    input  logic                         s_res_tlast,
    output logic                         s_res_tready,
    output logic [CHANNELS*SAMPLE_W-1:0] m_axis_tdata,
    output logic                         m_axis_tvalid,
    output logic                         m_axis_tlast,
    input  logic                         m_axis_tready,
    output logic                         busy,
    output logic                         frame_done,
    output logic                         pad_evt,
`ifdef FFT_FRAME_CTRL_STATS_EN
    output logic [15:0]                  stat_frames,
    output logic [15:0]                  stat_pad,
    output logic [15:0]                  stat_trunc,
`endif
    output logic                         trunc_evt
);
    localparam int DW    = CHANNELS * SAMPLE_W;
    localparam int CNT_W = MAX_LOG2_LEN;
    localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'((SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_ONES    = '1;
    localparam logic [4:0]       MIN_L       = 5'd3;
    localparam logic [4:0]       MAX_L       = 5'(MAX_LOG2_LEN);

    typedef enum logic [2:0] {IDLE, CONFIG, SETTLE, WRITE, PAD, DRAIN, WAIT_OUT} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SET_W-1:0] settle_q, settle_d;
    logic [4:0]       len_q, len_d;
    logic             fwd_q, fwd_d;
    logic             cfg_valid_q, cfg_valid_d;
    logic [DW-1:0]    dat_q, dat_d;
    logic             vld_q, vld_d;
    logic             lst_q, lst_d;
    logic             pad_evt_q, pad_evt_d;
    logic             trunc_evt_q, trunc_evt_d;

    logic [4:0]       clamp_len;
    logic [CNT_W-1:0] last_idx;
    logic             last_beat;
    logic             load;
    logic [CFG_W-1:0] cfg_word;

    // Shifting an all-ones mask by L yields N-1 directly, including L == MAX_LOG2_LEN.
    assign clamp_len = (cfg_log2_len < MIN_L) ? MIN_L :
                       (cfg_log2_len > MAX_L) ? MAX_L : cfg_log2_len;
    assign last_idx  = ~(CNT_ONES << len_q);
    assign last_beat = (cnt_q == last_idx);
    assign load      = !vld_q || m_fft_tready;

    always_comb begin
        cfg_word      = '0;
        cfg_word[4:0] = len_q;
        cfg_word[8]   = fwd_q;
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        settle_d      = settle_q;
        len_d         = len_q;
        fwd_d         = fwd_q;
        cfg_valid_d   = cfg_valid_q;
        dat_d         = dat_q;
        vld_d         = vld_q;
        lst_d         = lst_q;
        pad_evt_d     = 1'b0;
        trunc_evt_d   = 1'b0;
        s_axis_tready = 1'b0;
        frame_done    = 1'b0;
        // The output stage empties whenever it may load, unless a new beat replaces it below.
        if (load) begin
            vld_d = 1'b0;
            lst_d = 1'b0;
        end
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d     = CONFIG;
                    len_d       = clamp_len;
                    fwd_d       = cfg_fwd_inv;
                    cfg_valid_d = 1'b1;
                    cnt_d       = '0;
                end
            end
            CONFIG: begin
                if (cfg_valid_q && m_cfg_tready) begin
                    cfg_valid_d = 1'b0;
                    settle_d    = '0;
                    state_d     = (SETTLE_CYCLES == 0) ? WRITE : SETTLE;
                end
            end
            SETTLE: begin
                if (settle_q == SETTLE_LAST) state_d = WRITE;
                else                         settle_d = settle_q + SET_W'(1);
            end
            WRITE: begin
                s_axis_tready = load;
                if (load && s_axis_tvalid) begin
                    dat_d = s_axis_tdata;
                    vld_d = 1'b1;
                    lst_d = last_beat;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_beat) begin
                        state_d     = s_axis_tlast ? WAIT_OUT : DRAIN;
                        trunc_evt_d = !s_axis_tlast;
                    end else if (s_axis_tlast) begin
                        state_d   = PAD;
                        pad_evt_d = 1'b1;
                    end
                end
            end
            PAD: begin
                if (load) begin
                    dat_d = '0;
                    vld_d = 1'b1;
                    lst_d = last_beat;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_beat) state_d = WAIT_OUT;
                end
            end
            DRAIN: begin
                s_axis_tready = 1'b1;
                if (s_axis_tvalid && s_axis_tlast) state_d = WAIT_OUT;
            end
            WAIT_OUT: begin
                if (s_res_tvalid && m_axis_tready && s_res_tlast) begin
                    state_d    = IDLE;
                    frame_done = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            settle_q    <= '0;
            len_q       <= '0;
            fwd_q       <= 1'b0;
            cfg_valid_q <= 1'b0;
            dat_q       <= '0;
            vld_q       <= 1'b0;
            lst_q       <= 1'b0;
            pad_evt_q   <= 1'b0;
            trunc_evt_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            settle_q    <= settle_d;
            len_q       <= len_d;
            fwd_q       <= fwd_d;
            cfg_valid_q <= cfg_valid_d;
            dat_q       <= dat_d;
            vld_q       <= vld_d;
            lst_q       <= lst_d;
            pad_evt_q   <= pad_evt_d;
            trunc_evt_q <= trunc_evt_d;
        end
    end

    assign m_cfg_tdata   = cfg_word;
    assign m_cfg_tvalid  = cfg_valid_q;
    assign m_fft_tdata   = dat_q;
    assign m_fft_tvalid  = vld_q;
    assign m_fft_tlast   = lst_q;
    assign busy          = (state_q != IDLE);
    assign pad_evt       = pad_evt_q;
    assign trunc_evt     = trunc_evt_q;

    assign m_axis_tdata  = s_res_tdata;
    assign m_axis_tvalid = s_res_tvalid;
    assign m_axis_tlast  = s_res_tlast;
    assign s_res_tready  = m_axis_tready;

`ifdef FFT_FRAME_CTRL_STATS_EN
    logic [15:0] stat_frames_q, stat_pad_q, stat_trunc_q;

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            stat_frames_q <= '0;
            stat_pad_q    <= '0;
            stat_trunc_q  <= '0;
        end else begin
            if (frame_done && stat_frames_q != 16'hFFFF) stat_frames_q <= stat_frames_q + 16'd1;
            if (pad_evt_q && stat_pad_q != 16'hFFFF)     stat_pad_q    <= stat_pad_q + 16'd1;
            if (trunc_evt_q && stat_trunc_q != 16'hFFFF) stat_trunc_q  <= stat_trunc_q + 16'd1;
        end
    end

    assign stat_frames = stat_frames_q;
    assign stat_pad    = stat_pad_q;
    assign stat_trunc  = stat_trunc_q;
`endif
endmodule
